// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

   // Framer states: start bit is sampled in IDLE, then data, parity, stop.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   // Prefix bytes folded into flags on the following scan code.
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Queue entry layout for the default 8-bit scan code.
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO: the head entry is always presented on rdata_o.
// A pop and a push in the same cycle while full are both accepted.
module ps2_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [AW:0]                 wptr_q, rptr_q;
   logic                        pop_eff, push_eff;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty_o  = (wptr_q == rptr_q);
   assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_eff  = pop_i & ~empty_o;
   assign push_eff = push_i & (~full_o | pop_eff);
   assign rdata_o  = mem_q[rptr_q[AW-1:0]];

   // Storage and pointers; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_eff) mem_q[wptr_q[AW-1:0]] <= wdata_i;
         wptr_q <= wptr_q + {{AW{1'b0}}, push_eff};
         rptr_q <= rptr_q + {{AW{1'b0}}, pop_eff};
      end
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronises the bus, frames packets,
// folds E0/F0 prefixes into flags and queues finished scan codes.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic              clk,
   input  logic              res,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   input  logic              rd_en,
   output logic              valid,
   output logic [DATA_W-1:0] code,
   output logic              ext,
   output logic              brk,
   output logic              frame_err,
   output logic              overflow
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int EW = DATA_W + 2;

   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
   logic                   clk_prev_q, strb_q, samp_q;

   ps2_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [TW-1:0]     to_q, to_d;
   logic              perr_q, perr_d;
   logic              ext_q, ext_d, brk_q, brk_d;
   logic              ferr_q, ferr_d, ovf_q, ovf_d;
   logic              push;
   logic              full, empty;
   logic [EW-1:0]     head;

   // Synchronisers idle high; the strobe and its data sample are registered together.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
         strb_q     <= 1'b0;
         samp_q     <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         strb_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
         samp_q     <= dat_sync_q[SYNC_STAGES-1];
      end
   end

   // Framer next-state: bit sequencing, error tracking, prefix folding, timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      ferr_d  = 1'b0;
      push    = 1'b0;

      if (state_q == IDLE || strb_q) to_d = '0;
      else                           to_d = to_q + TW'(1);

      if (strb_q) begin
         case (state_q)
            IDLE: begin
               if (!samp_q) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  perr_d  = 1'b0;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            DATA: begin
               shift_d = {samp_q, shift_q[DATA_W-1:1]};
               if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
               else                          cnt_d   = cnt_q + CW'(1);
            end
            PARITY: begin
               perr_d  = ~(^shift_q ^ samp_q);
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (perr_q || !samp_q) begin
                  ferr_d = 1'b1;
                  ext_d  = 1'b0;
                  brk_d  = 1'b0;
               end else if (shift_q == DATA_W'(PS2_EXT)) begin
                  ext_d = 1'b1;
               end else if (shift_q == DATA_W'(PS2_BRK)) begin
                  brk_d = 1'b1;
               end else begin
                  push  = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYC - 1)) begin
         ferr_d  = 1'b1;
         ext_d   = 1'b0;
         brk_d   = 1'b0;
         state_d = IDLE;
         to_d    = '0;
      end
   end

   // A drop only happens when full and no simultaneous pop frees a slot.
   assign ovf_d = push & full & ~(rd_en & ~empty);

   // Framer state registers and one-cycle status pulses.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         to_q    <= '0;
         perr_q  <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         to_q    <= to_d;
         perr_q  <= perr_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         ferr_q  <= ferr_d;
         ovf_q   <= ovf_d;
      end
   end

   ps2_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (res),
      .push_i  (push),
      .wdata_i ({ext_q, brk_q, shift_q}),
      .pop_i   (rd_en),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign valid           = ~empty;
   assign {ext, brk, code} = head;
   assign frame_err       = ferr_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: expected entries are queued as frames
// are sent and compared against the FIFO head as it is drained.
module tb_ps2_scan_rx;

   localparam int TO = 5000;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       valid;
   logic [7:0] code;
   logic       ext, brk, frame_err, overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int fe_cnt  = 0;
   int ov_cnt  = 0;
   logic [9:0] sbq[$];

   ps2_scan_rx #(
      .DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .res(res), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .valid(valid), .code(code), .ext(ext), .brk(brk),
      .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Count high cycles of the status pulses.
   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overflow)  ov_cnt++;
   end

   // Send one frame (or its first nbits bits); optionally check write latency
   // or pop the head in the exact cycle the stop bit is written.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit chk_lat, input bit pop_at_stop);
      logic [10:0] bits;
      logic [9:0]  e;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data = bits[i];
         repeat (3) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            if (chk_lat) begin
               n_tests++;
               if (valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL lat_early: valid=%b required 0", valid);
               end
            end
            if (pop_at_stop) begin
               e = sbq.pop_front();
               n_tests++;
               if ({ext, brk, code} !== e) begin
                  n_fail++;
                  $display("FAIL pop_at_stop: got %h required %h", {ext, brk, code}, e);
               end
               rd_en = 1'b1;
            end
            @(negedge clk);
            rd_en = 1'b0;
            if (chk_lat) begin
               n_tests++;
               if (valid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL lat_valid: valid=%b required 1", valid);
               end
            end
            repeat (6) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         ps2_clk = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 11, 1'b0, 1'b0);
   endtask

   // Pop and compare until the scoreboard is empty, then expect valid low.
   task automatic drain(input string tag);
      logic [9:0] e;
      int guard;
      while (sbq.size() > 0) begin
         guard = 0;
         while (!valid && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         e = sbq.pop_front();
         n_tests++;
         if (!valid) begin
            n_fail++;
            $display("FAIL %s_timeout: valid=0 required entry %h", tag, e);
            sbq.delete();
            return;
         end
         if ({ext, brk, code} !== e) begin
            n_fail++;
            $display("FAIL %s_entry: got %h required %h", tag, {ext, brk, code}, e);
         end
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      n_tests++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_empty: valid=%b required 0", tag, valid);
      end
   endtask

   task automatic chk_cnt(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic test_reset();
      res = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b required 0", valid);
      end
      n_tests++;
      if ({code, ext, brk, frame_err, overflow} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h required 000", {code, ext, brk, frame_err, overflow});
      end
      res = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      int fe0 = fe_cnt;
      sbq.push_back({2'b00, 8'h1C});
      send_frame(8'h1C, 1'b0, 11, 1'b1, 1'b0);
      drain("single");
      chk_cnt("single_ferr", fe_cnt - fe0, 0);
   endtask

   task automatic test_prefix();
      int fe0 = fe_cnt;
      sbq.push_back({2'b01, 8'h1C});
      send(8'hF0);
      send(8'h1C);
      drain("brk");
      sbq.push_back({2'b11, 8'h75});
      sbq.push_back({2'b00, 8'h1C});
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      send(8'h1C);
      drain("extbrk");
      chk_cnt("prefix_ferr", fe_cnt - fe0, 0);
   endtask

   task automatic test_parity();
      int fe0 = fe_cnt;
      send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk_cnt("parity_ferr", fe_cnt - fe0, 1);
      n_tests++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_noentry: valid=%b required 0", valid);
      end
      sbq.push_back({2'b00, 8'h1C});
      send_frame(8'hF0, 1'b1, 11, 1'b0, 1'b0);
      send(8'h1C);
      drain("parity_clr");
      chk_cnt("parity_ferr2", fe_cnt - fe0, 2);
   endtask

   task automatic test_timeout();
      int fe0 = fe_cnt;
      send_frame(8'h75, 1'b0, 5, 1'b0, 1'b0);
      repeat (TO + 10) @(negedge clk);
      chk_cnt("timeout_ferr", fe_cnt - fe0, 1);
      sbq.push_back({2'b00, 8'h75});
      send(8'h75);
      drain("timeout_next");
      chk_cnt("timeout_ferr2", fe_cnt - fe0, 1);
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      int ov0 = ov_cnt;
      codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
      for (int i = 0; i < 4; i++) sbq.push_back({2'b00, codes[i]});
      for (int i = 0; i < 5; i++) send(codes[i]);
      chk_cnt("ovf_pulse", ov_cnt - ov0, 1);
      drain("ovf_order");
      for (int i = 0; i < 4; i++) begin
         sbq.push_back({2'b00, codes[i]});
         send(codes[i]);
      end
      sbq.push_back({2'b00, codes[4]});
      send_frame(codes[4], 1'b0, 11, 1'b0, 1'b1);
      chk_cnt("ovf_popfirst", ov_cnt - ov0, 1);
      drain("ovf_popfirst");
   endtask

   task automatic test_reset_mid();
      send(8'h1C);
      send_frame(8'h75, 1'b0, 6, 1'b0, 1'b0);
      @(negedge clk);
      res = 1'b0;
      #1;
      n_tests++;
      if ({valid, code, ext, brk, frame_err, overflow} !== 13'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got %h required 0000",
                  {valid, code, ext, brk, frame_err, overflow});
      end
      sbq.delete();
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      res = 1'b1;
      repeat (3) @(negedge clk);
      sbq.push_back({2'b00, 8'h1C});
      send(8'h1C);
      drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_prefix();
      test_parity();
      test_timeout();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
